// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-shared sequence detector.
// No logic; holds the FSM enum, the reset pattern and an index-width helper.
// No flow control of its own.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CFG  = 2'd2
    } state_t;

    // Reset pattern 101; narrower patterns keep only the LSBs, wider ones are zero-padded.
    localparam logic [7:0] PAT_RST = 8'b0000_0101;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Grant is combinational (zero latency); the pointer advances past the winner at the edge.
// No grant and pointer hold while en is low or nothing requests.
module seq_rr_arb
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int IW = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_CH)) begin
                cand = cand - (IW+1)'(NUM_CH);
            end
            if (en && !found && req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IW-1:0]]     = 1'b1;
                gnt_idx               = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one pattern matcher among NUM_CH serial streams; SEQ_DET_SCHED_NOOVL_EN selects non-overlapping matches.
// Latency: hit is registered one cycle after the consuming grant; gnt is combinational.
// Backpressure: a channel holds req/bit_in until gnt; no grants while disabled or in CFG.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] bit_in,
    output logic [NUM_CH-1:0] gnt,
    output logic [NUM_CH-1:0] hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic              busy
);

    localparam int IW = idx_w(NUM_CH);
    localparam int FW = idx_w(PAT_W + 1);

    state_t            state;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist [NUM_CH];
    logic [FW-1:0]     fill [NUM_CH];

    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic [PAT_W-1:0]  hist_new;
    logic [FW-1:0]     fill_new;
    logic              match;

    seq_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == RUN) && enable),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pattern <= PAT_RST[PAT_W-1:0];
            busy    <= 1'b0;
        end else begin
            busy <= 1'b0;
            if (cfg_we) begin
                state   <= CFG;
                pattern <= cfg_pattern;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE:    if (enable) state <= RUN;
                    RUN:     if (!enable) state <= IDLE;
                    default: state <= enable ? RUN : IDLE;
                endcase
            end
        end
    end

    // A grant in the cfg_we cycle still matches against the pattern held before the load.
    always_comb begin
        gnt_vld  = |gnt;
        hist_new = {hist[gnt_idx][PAT_W-2:0], bit_in[gnt_idx]};
        fill_new = (fill[gnt_idx] == FW'(PAT_W)) ? fill[gnt_idx] : fill[gnt_idx] + 1'b1;
        match    = gnt_vld && (hist_new == pattern) && (fill_new == FW'(PAT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hist[k] <= '0;
                fill[k] <= '0;
            end
            hit       <= '0;
            hit_count <= '0;
        end else begin
            hit <= '0;
            if (match) begin
                hit[gnt_idx] <= 1'b1;
                if (hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
            end
            if (state == CFG) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    hist[k] <= '0;
                    fill[k] <= '0;
                end
            end else if (gnt_vld) begin
`ifdef SEQ_DET_SCHED_NOOVL_EN
                if (match) begin
                    hist[gnt_idx] <= '0;
                    fill[gnt_idx] <= '0;
                end else begin
                    hist[gnt_idx] <= hist_new;
                    fill[gnt_idx] <= fill_new;
                end
`else
                hist[gnt_idx] <= hist_new;
                fill[gnt_idx] <= fill_new;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed self-checking bench for seq_det_sched at default parameters.
module tb_seq_det_sched;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       cfg_we;
    logic [2:0] cfg_pattern;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] gnt;
    logic [3:0] hit;
    logic [7:0] hit_count;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_sched dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .req         (req),
        .bit_in      (bit_in),
        .gnt         (gnt),
        .hit         (hit),
        .hit_count   (hit_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_pattern = 3'b000;
        req = 4'b0000; bit_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offers one bit on channel k and returns one step after the consuming edge.
    task automatic send_bit(input logic [1:0] k, input logic b);
        int waited;
        waited = 0;
        req[k] = 1'b1;
        bit_in[k] = b;
        #1;
        while (gnt[k] !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (gnt[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_wait ch%0d: gnt=%b, required bit %0d set", k, gnt, k);
        end
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; cfg_we = 1'b0; cfg_pattern = 3'b000;
        req = 4'b1111; bit_in = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL reset_hit: got %b want 0000", hit); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", hit_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        req = 4'b0000; enable = 1'b0;
    endtask

    task automatic test_single_stream();
        logic [4:0] stream;
        logic [4:0] exp_hits;
        logic [7:0] exp_cnt;
        stream = 5'b10101;
`ifdef SEQ_DET_SCHED_NOOVL_EN
        exp_hits = 5'b00100; exp_cnt = 8'd1;
`else
        exp_hits = 5'b10100; exp_cnt = 8'd2;
`endif
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++) begin
            send_bit(2'd0, stream[4-i]);
            n_checks++;
            if (hit !== {3'b000, exp_hits[i]}) begin
                n_fail++;
                $display("FAIL single_hit bit%0d: got %b want %b", i, hit, {3'b000, exp_hits[i]});
            end
        end
        n_checks++;
        if (hit_count !== exp_cnt) begin n_fail++; $display("FAIL single_count: got %0d want %0d", hit_count, exp_cnt); end
        @(posedge clk); #1;
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL single_hit_pulse: got %b want 0000", hit); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [3:0] exp_hit;
        do_reset();
        start_run();
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            bit_in = {1'b0, (i / 4 == 1) ? 1'b0 : 1'b1, 2'b00};
            #1;
            exp_gnt = 4'b0001 << (i % 4);
            exp_hit = (i == 11) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt cycle%0d: got %b want %b", i, gnt, exp_gnt); end
            n_checks++;
            if (hit !== exp_hit) begin n_fail++; $display("FAIL rr_hit cycle%0d: got %b want %b", i, hit, exp_hit); end
            @(posedge clk); #1;
        end
        req = 4'b0000;
    endtask

    task automatic test_cfg();
        do_reset();
        start_run();
        send_bit(2'd1, 1'b1);
        send_bit(2'd1, 1'b0);
        cfg_we = 1'b1; cfg_pattern = 3'b110;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        req[1] = 1'b1; bit_in[1] = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfg_busy: got %b want 1", busy); end
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL cfg_gnt: got %b want 0000", gnt); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_drop: got %b want 0", busy); end
        send_bit(2'd1, 1'b1);
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL cfg_hit_a: got %b want 0000", hit); end
        send_bit(2'd1, 1'b1);
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL cfg_hit_b: got %b want 0000", hit); end
        send_bit(2'd1, 1'b0);
        n_checks++; if (hit !== 4'b0010) begin n_fail++; $display("FAIL cfg_hit_c: got %b want 0010", hit); end
        // Partial 11 must not survive a reconfiguration.
        send_bit(2'd1, 1'b1);
        send_bit(2'd1, 1'b1);
        cfg_we = 1'b1; cfg_pattern = 3'b110;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        send_bit(2'd1, 1'b0);
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL cfg_discard: got %b want 0000", hit); end
        // Grant coinciding with cfg_we completes against the old pattern 110.
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b1);
        req[0] = 1'b1; bit_in[0] = 1'b0;
        cfg_we = 1'b1; cfg_pattern = 3'b011;
        #1;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL cfg_same_gnt: got %b want 0001", gnt); end
        @(posedge clk); #1;
        cfg_we = 1'b0; req = 4'b0000;
        n_checks++; if (hit !== 4'b0001) begin n_fail++; $display("FAIL cfg_same_hit: got %b want 0001", hit); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfg_same_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        send_bit(2'd0, 1'b0);
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b1);
        n_checks++; if (hit !== 4'b0001) begin n_fail++; $display("FAIL cfg_new_pat: got %b want 0001", hit); end
    endtask

    task automatic test_pause();
        do_reset();
        start_run();
        send_bit(2'd3, 1'b1);
        send_bit(2'd3, 1'b0);
        enable = 1'b0;
        req[3] = 1'b1; bit_in[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL pause_gnt cycle%0d: got %b want 0000", i, gnt); end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        send_bit(2'd3, 1'b1);
        n_checks++; if (hit !== 4'b1000) begin n_fail++; $display("FAIL pause_hit: got %b want 1000", hit); end
        @(posedge clk); #1;
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL pause_hit_once: got %b want 0000", hit); end
        n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL pause_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        start_run();
        for (int r = 0; r < 255; r++) begin
            send_bit(2'd0, 1'b1);
            send_bit(2'd0, 1'b0);
            send_bit(2'd0, 1'b1);
        end
        n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d want 255", hit_count); end
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b0);
        send_bit(2'd0, 1'b1);
        n_checks++; if (hit !== 4'b0001) begin n_fail++; $display("FAIL sat_hit: got %b want 0001", hit); end
        n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", hit_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run();
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b0);
        send_bit(2'd0, 1'b1);
        send_bit(2'd0, 1'b0);
        n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 1", hit_count); end
        rst = 1'b0;
        req[0] = 1'b1; bit_in[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_hit: got %b want 0000", hit); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", hit_count); end
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        send_bit(2'd0, 1'b1);
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL mid_post_hit: got %b want 0000", hit); end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_cfg();
        test_pause();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Time-shares one pattern-match engine among NUM_CH serial bit streams.
- Each cycle, a round-robin arbiter grants one requesting channel. Its bit is shifted into that channel's saved history, and a hit is flagged when the history equals the programmed pattern.
- Sits between the serial front-ends and the event/status logic. Replaces per-channel detector instances.

Parameters:
- NUM_CH, 4, number of requesting serial channels (2..8).
- PAT_W, 3, pattern length in bits (2..8); reset pattern is 101 padded or truncated to PAT_W LSBs (3'b101 at default).
- CNT_W, 8, width of the saturating total-hit counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  1 = arbitrate and match; 0 = no grants.
- cfg_we  in  1  one-cycle pulse: load cfg_pattern.
- cfg_pattern  in  PAT_W  new pattern; MSB is the oldest bit.
- req  in  NUM_CH  per-channel request; a bit is offered.
- bit_in  in  NUM_CH  per-channel data bit; must be stable while req is high.
- gnt  out  NUM_CH  one-hot; the bit of the granted channel is consumed this cycle.
- hit  out  NUM_CH  one-cycle pulse per channel on a pattern match.
- hit_count  out  CNT_W  total hits, saturating.
- busy  out  1  high in state CFG.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; pattern=reset value; all histories and fill counters = 0.
  - rr pointer = 0; gnt=0, hit=0, hit_count=0, busy=0.
- FSM states:
  - IDLE: gnt=0. Goes to RUN when enable=1.
  - RUN: arbitrate. Goes to IDLE when enable=0.
  - CFG: exactly one cycle. Loads the pattern and clears all histories and fill counters; gnt=0, busy=1. Next state is RUN if enable=1, else IDLE.
  - cfg_we in any state moves to CFG next cycle. cfg_we has priority over an enable change.
- Arbitration (RUN only):
  - gnt is combinational from req and the rr pointer: first requester at or after the pointer, wrapping from NUM_CH-1 to 0.
  - On grant to channel k, the pointer becomes (k+1) mod NUM_CH at the edge.
  - No request means gnt=0 and the pointer holds.
  - A requester waits at most NUM_CH-1 grant cycles.
- Handshake:
  - The bit is consumed at the clk edge where req[k]&gnt[k]=1.
  - The requester may drop req or present the next bit after that edge.
  - Dropping req without a grant is legal; nothing is consumed.
- Match (per channel k, on consumption):
  - hist_k <= {hist_k[PAT_W-2:0], bit_in[k]}.
  - fill_k increments, saturating at PAT_W.
  - hit[k] is registered and asserted the cycle after the grant if the new history equals the pattern and the new fill_k = PAT_W. Latency = 1.
  - Overlapping matches count: with 101, the stream 10101 gives 2 hits.
- hit_count:
  - Increments by 1 per hit pulse and saturates at 2^CNT_W-1.
  - Reset clears it; CFG does not.
- Boundaries:
  - enable dropping mid-RUN keeps histories intact (the stream pauses).
  - A cfg_we pulse in the same cycle as a grant: that grant is still consumed against the old pattern, and its hit is still issued. CFG then clears all histories.
  - Reset mid-operation takes priority over everything.

Optional Feature:
- Macro: SEQ_DET_SCHED_NOOVL_EN.
- When defined: non-overlapping detection. On a hit, that channel's history and fill counter clear to 0, so 10101 gives 1 hit and 1010101 gives 2.
- When undefined: overlapping behaviour as above.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, RUN, CFG);
  - the reset pattern constant PAT_RST = 101;
  - a clog2-based channel-index width helper.
- One sub-module, seq_rr_arb: NUM_CH round-robin arbiter with the pointer and one-hot gnt.
- Per-channel history, fill counters and match compare stay in seq_det_sched.

Test Plan:
- Single channel 0 streams 1,0,1,0,1 with enable=1 and default pattern -> hit[0] pulses 1 cycle after the 3rd and 5th grants; hit_count=2 (1 with NOOVL_EN).
- All 4 channels hold req=1 continuously -> gnt sequence is 0001,0010,0100,1000,0001. Histories stay independent: interleaved 101 on ch2 only gives hit[2] alone.
- Ch1 receives 1,0, then cfg_we with cfg_pattern=110, then 1,1,0 -> busy is high for 1 cycle with no gnt; the old partial match is discarded; hit[1] fires after the final 0.
- enable=0 after ch3 has received 1,0; hold 5 cycles; enable=1; send 1 -> gnt=0 while disabled, then hit[3] fires once after the resumed bit.
- Force hit_count to 255 by streaming 101 patterns (CNT_W=8), then one more hit -> hit_count stays 255.
- Drive rst=0 mid-stream after 1,0 on ch0, release, then send 1 -> no hit; gnt, hit and hit_count read 0 during reset.
